// File: rtl/stage0.sv
// Fetch stage: issues instruction-memory reads from a running PC and buffers the
// returned words in a 2-entry FIFO presented to decode with a hold-cycle counter.
module stage0 #(
    parameter int PC_WIDTH    = 10,
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   branch_mispredict,
    input  logic [PC_WIDTH-1:0]    new_PC,
    output logic [PC_WIDTH-1:0]    inst_mem_addr,
    output logic                   inst_mem_rd_en,
    input  logic [63:0]            inst_mem_data,
    output logic [63:0]            instr_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    input  logic                   cnt_en,
    output logic [COUNT_WIDTH-1:0] ocount,
    output logic                   vld,
    input  logic                   next_rdy,
    output logic                   state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_n;
    logic                    rst_q;
    logic [PC_WIDTH-1:0]     pc_q, pc_n;
    logic [1:0]              occ_q, occ_n, occ_after;
    logic                    inflight_q, inflight_n;
    logic [63:0]             instr_q [2];
    logic [63:0]             instr_n [2];
    logic [PC_WIDTH-1:0]     epc_q   [2];
    logic [PC_WIDTH-1:0]     epc_n   [2];
    logic [COUNT_WIDTH-1:0]  cnt_q   [2];
    logic [COUNT_WIDTH-1:0]  cnt_n   [2];
    logic                    pop, push, flush, rd_en;
    logic [2:0]              slots;

    function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] c,
                                                    input logic en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    // Assertion of rst clears everything at once; release is taken on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_q <= 1'b0;
        else      rst_q <= 1'b1;
    end

    // Handshake toward decode: the head transfers on any cycle where vld && next_rdy;
    // while vld is high and next_rdy low the head is held unchanged (flushes excepted).
    assign vld   = (occ_q != 2'd0);
    assign pop   = vld && next_rdy;
    assign flush = halt || branch_mispredict;
    assign push  = inflight_q && !flush;

    // A read is only issued when its returning word is guaranteed a free slot.
    assign slots = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en = (state_q == RUN) && !branch_mispredict && !halt && (slots < 3'd2);

    assign inst_mem_rd_en = rd_en;
    assign inst_mem_addr  = pc_q;
    assign instr_out      = instr_q[0];
    assign pc_out         = epc_q[0];
    assign ocount         = cnt_q[0];
    assign state_dbg      = state_q;

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (start) state_n = RUN;
            RUN:  if (halt)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        pc_n = pc_q;
        if (state_q == IDLE && start) pc_n = '0;
        else if (halt)                pc_n = pc_q;
        else if (branch_mispredict)   pc_n = new_PC;
        else if (rd_en)               pc_n = pc_q + 1'b1;
    end

    assign inflight_n = rd_en;

    always_comb begin
        instr_n   = instr_q;
        epc_n     = epc_q;
        cnt_n     = cnt_q;
        occ_n     = occ_q;
        occ_after = occ_q - {1'b0, pop};
        if (flush) begin
            occ_n = 2'd0;
        end else begin
            if (pop) begin
                instr_n[0] = instr_q[1];
                epc_n[0]   = epc_q[1];
                cnt_n[0]   = cnt_q[1];
            end
            cnt_n[0] = bump(cnt_n[0], cnt_en);
            cnt_n[1] = bump(cnt_n[1], cnt_en);
            if (push) begin
                if (occ_after == 2'd0) begin
                    instr_n[0] = inst_mem_data;
                    epc_n[0]   = pc_q - 1'b1;
                    cnt_n[0]   = '0;
                end else begin
                    instr_n[1] = inst_mem_data;
                    epc_n[1]   = pc_q - 1'b1;
                    cnt_n[1]   = '0;
                end
            end
            occ_n = occ_after + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst_q) begin
        if (!rst_q) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            occ_q      <= occ_n;
            inflight_q <= inflight_n;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= instr_n[i];
                epc_q[i]   <= epc_n[i];
                cnt_q[i]   <= cnt_n[i];
            end
        end
    end

endmodule

// File: tb/tb_stage0.sv
// Directed bench for stage0: streaming, stall/saturation, redirect with PC wrap,
// halt+redirect collision and asynchronous reset mid-stream.
module tb_stage0;
    localparam int PW = 10;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, halt = 1'b0, branch_mispredict = 1'b0;
    logic [PW-1:0] new_PC = '0;
    logic [PW-1:0] inst_mem_addr;
    logic          inst_mem_rd_en;
    logic [63:0]   inst_mem_data = '0;
    logic [63:0]   instr_out;
    logic [PW-1:0] pc_out;
    logic          cnt_en = 1'b0;
    logic [CW-1:0] ocount;
    logic          vld;
    logic          next_rdy = 1'b0;
    logic          state_dbg;

    logic          cnt_clr = 1'b0;
    int            rd_cnt = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [PW-1:0] e;

    always #5 clk = ~clk;

    stage0 #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .branch_mispredict(branch_mispredict), .new_PC(new_PC),
        .inst_mem_addr(inst_mem_addr), .inst_mem_rd_en(inst_mem_rd_en),
        .inst_mem_data(inst_mem_data), .instr_out(instr_out), .pc_out(pc_out),
        .cnt_en(cnt_en), .ocount(ocount), .vld(vld), .next_rdy(next_rdy),
        .state_dbg(state_dbg)
    );

    // Memory: word k holds value k, returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (inst_mem_rd_en) inst_mem_data <= 64'(inst_mem_addr);
    end

    always @(posedge clk) begin
        if (cnt_clr)             rd_cnt <= 0;
        else if (inst_mem_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) cyc();
        sample();
        check("rst_vld", vld, 0);
        check("rst_rd_en", inst_mem_rd_en, 0);
        check("rst_addr", inst_mem_addr, 0);
        check("rst_instr", instr_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_ocount", ocount, 0);
        check("rst_state", state_dbg, 0);
        cyc();
        rst = 1'b1;
        repeat (2) cyc();

        // Basic streaming
        next_rdy = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        sample();
        check("c1_rd_en", inst_mem_rd_en, 1);
        check("c1_addr", inst_mem_addr, 0);
        check("c1_vld", vld, 0);
        cyc(); sample();
        check("c2_rd_en", inst_mem_rd_en, 1);
        check("c2_addr", inst_mem_addr, 1);
        check("c2_vld", vld, 0);
        cyc(); sample();
        check("c3_vld", vld, 1);
        check("c3_instr", instr_out, 0);
        check("c3_pc", pc_out, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); sample();
            check("stream_instr", instr_out, 64'(k));
            check("stream_pc", pc_out, 64'(k));
        end
        cyc();
        halt = 1'b1;
        sample();
        check("halt_no_rd", inst_mem_rd_en, 0);
        cyc();
        halt = 1'b0;
        sample();
        check("halt_vld", vld, 0);
        check("halt_state", state_dbg, 0);
        check("halt_rd_en", inst_mem_rd_en, 0);

        // Stall with counting and saturation
        next_rdy = 1'b0;
        cnt_en = 1'b1;
        cnt_clr = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cnt_clr = 1'b0;
        cyc(); cyc(); sample();
        check("stall_vld", vld, 1);
        check("stall_instr0", instr_out, 0);
        check("stall_cnt0", ocount, 0);
        for (int k = 1; k <= 9; k++) begin
            cyc(); sample();
            check("stall_hold", instr_out, 0);
        end
        check("stall_cnt9", ocount, 9);
        check("stall_reads", rd_cnt, 2);
        repeat (61) cyc();
        sample();
        check("stall_sat", ocount, 63);
        check("stall_instr_long", instr_out, 0);
        check("stall_reads_long", rd_cnt, 2);
        cyc();
        next_rdy = 1'b1;
        sample();
        check("rel_instr0", instr_out, 0);
        cyc(); sample();
        check("rel_instr1", instr_out, 1);
        check("rel_cnt1_sat", ocount, 63);
        cyc(); sample();
        check("rel_instr2", instr_out, 2);
        check("rel_cnt2", ocount, 0);
        cyc(); sample();
        check("rel_instr3", instr_out, 3);

        // Redirect while streaming, then run across the PC wrap
        cyc();
        branch_mispredict = 1'b1;
        new_PC = 10'h3F2;
        sample();
        check("mp_no_rd", inst_mem_rd_en, 0);
        cyc();
        branch_mispredict = 1'b0;
        sample();
        check("mp_vld_drop", vld, 0);
        check("mp_rd_en", inst_mem_rd_en, 1);
        check("mp_addr", inst_mem_addr, 10'h3F2);
        cyc(); sample();
        check("mp_vld_still0", vld, 0);
        check("mp_addr2", inst_mem_addr, 10'h3F3);
        for (int j = 0; j < 16; j++) begin
            cyc(); sample();
            e = 10'h3F2 + 10'(j);
            check("wrap_vld", vld, 1);
            check("wrap_pc", pc_out, 64'(e));
            check("wrap_instr", instr_out, 64'(e));
        end

        // Halt colliding with a redirect
        cyc();
        halt = 1'b1;
        branch_mispredict = 1'b1;
        new_PC = 10'h155;
        cyc();
        halt = 1'b0;
        branch_mispredict = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            check("hb_state", state_dbg, 0);
            check("hb_vld", vld, 0);
            check("hb_rd_en", inst_mem_rd_en, 0);
            cyc();
        end

        // Asynchronous reset mid-stream
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        sample();
        check("pre_rst_vld", vld, 1);
        check("pre_rst_pc", pc_out, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_vld", vld, 0);
        check("arst_rd_en", inst_mem_rd_en, 0);
        check("arst_addr", inst_mem_addr, 0);
        check("arst_instr", instr_out, 0);
        check("arst_pc", pc_out, 0);
        check("arst_ocount", ocount, 0);
        cyc(); cyc();
        rst = 1'b1;
        repeat (2) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        sample();
        check("restart_rd_en", inst_mem_rd_en, 1);
        check("restart_addr", inst_mem_addr, 0);
        cyc(); cyc(); sample();
        check("restart_vld", vld, 1);
        check("restart_pc", pc_out, 0);
        check("restart_instr", instr_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stage0.md
STAGE0 -- requirements
Module: stage0

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, instruction-memory address width.
REQ-002 SHALL have parameter COUNT_WIDTH, default 6, per-instruction cycle-count width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins fetching at PC 0.
REQ-006 SHALL have port halt  input  1  one-cycle pulse from a downstream RET; stops fetching.
REQ-007 SHALL have port branch_mispredict  input  1  redirect request from a later stage.
REQ-008 SHALL have port new_PC  input  PC_WIDTH  redirect target, sampled with branch_mispredict.
REQ-009 SHALL have port inst_mem_addr  output  PC_WIDTH  instruction memory read address.
REQ-010 SHALL have port inst_mem_rd_en  output  1  instruction memory read strobe.
REQ-011 SHALL have port inst_mem_data  input  64  read data, valid exactly one cycle after rd_en.
REQ-012 SHALL have port instr_out  output  64  head instruction to decode.
REQ-013 SHALL have port pc_out  output  PC_WIDTH  address of the head instruction.
REQ-014 SHALL have port cnt_en  input  1  cycle-count enable.
REQ-015 SHALL have port ocount  output  COUNT_WIDTH  cycles the head instruction has been held.
REQ-016 SHALL have ports vld output 1 and next_rdy input 1: valid/ready handshake toward decode.

Function
REQ-017 SHALL implement states IDLE and RUN; start in IDLE -> RUN with PC <= 0; halt in RUN -> IDLE; start in RUN ignored.
REQ-018 SHALL hold a 2-entry FIFO of {instr, pc, count}; vld = (occupancy != 0); instr_out/pc_out/ocount reflect the head entry.
REQ-019 SHALL pop the head on any cycle with vld && next_rdy; pop and push in the same cycle both take effect.
REQ-020 SHALL assert inst_mem_rd_en only when state==RUN, !branch_mispredict, !halt, and (occupancy + inflight - pop) < 2, so a returning word always has a free slot.
REQ-021 SHALL drive inst_mem_addr = PC combinationally; on each issued read PC <= PC+1, wrapping from 2^PC_WIDTH-1 to 0.
REQ-022 SHALL set an inflight flag on each issued read and push inst_mem_data with its PC on the following edge; read-to-vld latency is 2 cycles.
REQ-023 SHALL load count 0 on push and increment every held entry's count by 1 on each cycle cnt_en is high, saturating at 2^COUNT_WIDTH-1.
REQ-024 On branch_mispredict SHALL: PC <= new_PC, FIFO emptied, pending inflight response discarded, no read that cycle; first redirected read issues on the next cycle.
REQ-025 On halt SHALL empty the FIFO, discard any inflight response and enter IDLE; halt dominates a simultaneous branch_mispredict.
REQ-026 SHALL never change instr_out/pc_out while vld && !next_rdy, except by flush (REQ-024, REQ-025).
REQ-027 In IDLE SHALL keep inst_mem_rd_en low and vld low.

Reset
REQ-028 While rst is low SHALL force: state IDLE, PC 0, occupancy 0, inflight 0, all counts 0, vld 0, inst_mem_rd_en 0, inst_mem_addr 0, instr_out 0, pc_out 0, ocount 0.
REQ-029 Reset assertion mid-fetch SHALL take effect immediately (asynchronously); deassertion is synchronised to clk, and start is ignored until the first edge after deassertion.

Verification
REQ-030 Start pulse, next_rdy=1, memory word k = k -> rd_en every cycle from cycle 1, vld at cycle 3 with instr_out=0/pc_out=0, then 1,2,3 on consecutive cycles.
REQ-031 next_rdy held 0 for 10 cycles after first vld -> exactly 2 reads issued in that window, instr_out stays 0, ocount reaches 9 with cnt_en=1, no word lost on release (sequence 0,1,2,...).
REQ-032 branch_mispredict with new_PC=0x3F2 while FIFO full and a read inflight -> vld drops next cycle, next rd_en addr 0x3F2, next vld shows pc_out=0x3F2.
REQ-033 PC reaches 0x3FF with PC_WIDTH=10 -> next issued address 0x000.
REQ-034 halt and branch_mispredict in same cycle -> IDLE, no further rd_en, vld 0 until next start.
REQ-035 rst driven low mid-stream with vld=1 -> all outputs 0 without waiting for a clock edge; after release, start restarts from PC 0.
